snoop_bus_ctrl: RTL

- Parametrised snooping-bus controller for an MSI coherence system: arbitrates N private caches onto one shared bus, broadcasts coherence messages, collects dirty write-backs from snooping owners and serves requests from a shared word-addressed memory.
- Successor to the fixed 3-cache bus/memory block: N caches, address/data widths, round-robin arbitration, request/grant handshake, eviction path and explicit response strobe are all new.

---
 rtl/snoop_bus_ctrl_if.sv | 35 +++
 rtl/snoop_bus_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/snoop_bus_ctrl_if.sv
// Bus bundle between the N private caches and snoop_bus_ctrl: requests, broadcast, snoop replies, completion.
// master = cache side, slave = controller side.
interface snoop_bus_ctrl_if #(
  parameter int N_CACHES = 3,
  parameter int AW       = 3,
  parameter int DW       = 8
);
  localparam int IW = (N_CACHES > 1) ? $clog2(N_CACHES) : 1;

  logic [N_CACHES-1:0]    req;
  logic [2*N_CACHES-1:0]  req_op;
  logic [AW*N_CACHES-1:0] req_addr;
  logic [DW*N_CACHES-1:0] req_wdata;
  logic [N_CACHES-1:0]    grant;
  logic                   bus_valid;
  logic [1:0]             bus_msg;
  logic [AW-1:0]          bus_addr;
  logic [IW-1:0]          bus_src;
  logic [N_CACHES-1:0]    snoop_dirty;
  logic [DW*N_CACHES-1:0] snoop_wb_data;
  logic                   resp_valid;
  logic [IW-1:0]          resp_id;
  logic [DW-1:0]          resp_data;
  logic                   busy;

  modport master (
    output req, req_op, req_addr, req_wdata, snoop_dirty, snoop_wb_data,
    input  grant, bus_valid, bus_msg, bus_addr, bus_src, resp_valid, resp_id, resp_data, busy
  );

  modport slave (
    input  req, req_op, req_addr, req_wdata, snoop_dirty, snoop_wb_data,
    output grant, bus_valid, bus_msg, bus_addr, bus_src, resp_valid, resp_id, resp_data, busy
  );
endinterface

// File: rtl/snoop_bus_ctrl.sv
// MSI snooping-bus controller: round-robin arbitration, coherence broadcast, dirty write-back, shared memory.
// Define SNOOP_FWD_EN to forward owner data straight to the requester from WB (skips the MEM read).
module snoop_bus_ctrl #(
  parameter int N_CACHES = 3,
  parameter int AW       = 3,
  parameter int DW       = 8
) (
  input  logic           clock,
  input  logic           reset,
  snoop_bus_ctrl_if.slave bus
);
  localparam int IW = (N_CACHES > 1) ? $clog2(N_CACHES) : 1;

  typedef enum logic [2:0] {IDLE, BCAST, SNOOP, WB, MEM, EVICT, RESP} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] curIdx;
  logic [1:0]    curOp;
  logic [AW-1:0] curAddr;
  logic [DW-1:0] curWdata;
  logic [DW-1:0] ownerData;
  logic [DW-1:0] mem [2**AW];

  logic          found;
  logic [IW-1:0] winner;
  logic [1:0]    winOp;
  logic [AW-1:0] winAddr;
  logic [DW-1:0] winWdata;
  int            cand;
  logic [N_CACHES-1:0] effDirty;
  logic [DW-1:0] dirtyData;

  // Round-robin pick: first requester at or after ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = 0; k < N_CACHES; k++) begin
      cand = (int'(ptr) + k) % N_CACHES;
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = IW'(cand);
      end
    end
    winOp    = bus.req_op[int'(winner)*2 +: 2];
    winAddr  = bus.req_addr[int'(winner)*AW +: AW];
    winWdata = bus.req_wdata[int'(winner)*DW +: DW];
  end

  // The requester never supplies its own line; lowest-index owner wins if several claim it.
  always_comb begin
    effDirty         = bus.snoop_dirty;
    effDirty[curIdx] = 1'b0;
    dirtyData        = '0;
    for (int i = N_CACHES - 1; i >= 0; i--) begin
      if (effDirty[i]) dirtyData = bus.snoop_wb_data[i*DW +: DW];
    end
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && found) begin
      curIdx   <= winner;
      curOp    <= winOp;
      curAddr  <= winAddr;
      curWdata <= winWdata;
    end
    if (state == SNOOP) ownerData <= dirtyData;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (state == WB) begin
      mem[curAddr] <= ownerData;
    end else if (state == EVICT) begin
      mem[curAddr] <= curWdata;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      ptr            <= '0;
      bus.grant      <= '0;
      bus.bus_valid  <= 1'b0;
      bus.bus_msg    <= 2'b00;
      bus.bus_addr   <= '0;
      bus.bus_src    <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_id    <= '0;
      bus.resp_data  <= '0;
      bus.busy       <= 1'b0;
    end else begin
      bus.grant      <= '0;
      bus.bus_valid  <= 1'b0;
      bus.bus_msg    <= 2'b00;
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            bus.grant <= N_CACHES'(1) << winner;
            bus.busy  <= 1'b1;
            if (winOp == 2'b00) begin
              state <= EVICT;
            end else begin
              state         <= BCAST;
              bus.bus_valid <= 1'b1;
              bus.bus_msg   <= winOp;
              bus.bus_addr  <= winAddr;
              bus.bus_src   <= winner;
            end
          end
        end
        BCAST: state <= SNOOP;
        SNOOP: begin
          if (curOp == 2'b11) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_id    <= curIdx;
            bus.resp_data  <= '0;
          end else if (|effDirty) begin
            state <= WB;
          end else begin
            state <= MEM;
          end
        end
        WB: begin
`ifdef SNOOP_FWD_EN
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_id    <= curIdx;
          bus.resp_data  <= ownerData;
`else
          state <= MEM;
`endif
        end
        MEM: begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_id    <= curIdx;
          bus.resp_data  <= mem[curAddr];
        end
        EVICT: begin
          state          <= RESP;
          bus.resp_valid <= 1'b1;
          bus.resp_id    <= curIdx;
          bus.resp_data  <= '0;
        end
        RESP: begin
          ptr      <= (curIdx == IW'(N_CACHES - 1)) ? '0 : curIdx + 1'b1;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
